// File: rtl/magic_pkg.sv
// Shared types and defaults for the MAGIC NOR evaluator.
//   op_e    : micro-op encoding (INIT / NOR / READ / END)
//   ins_t   : instruction word layout {op, dst, a, b, c} at default sizes
//   state_e : sequencer states
package magic_pkg;

    localparam int unsigned CELLS_DEF = 32;
    localparam int unsigned IN_W_DEF  = 8;
    localparam int unsigned AW_DEF    = $clog2(CELLS_DEF);

    typedef enum logic [1:0] {
        OP_INIT = 2'b00,
        OP_NOR  = 2'b01,
        OP_READ = 2'b10,
        OP_END  = 2'b11
    } op_e;

    typedef struct packed {
        op_e               op;
        logic [AW_DEF-1:0] dst;
        logic [AW_DEF-1:0] a;
        logic [AW_DEF-1:0] b;
        logic [AW_DEF-1:0] c;
    } ins_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_OUT  = 2'b10
    } state_e;

endpackage

// File: rtl/magic_cell_array.sv
// MAGIC bit-cell array.
//   clk, rst         : clock, async active-high reset (all cells -> 1)
//   load_en/load_vec : bulk load; low IN_W cells take load_vec, the rest go to 1
//   set_en           : INIT, cells[wr_addr] = 1
//   nor_en           : NOR, cells[wr_addr] &= ~(ra|rb|rc)
//   wr_addr          : destination cell for set/nor
//   r*_addr/r*_data  : three asynchronous read ports; out-of-range reads give 1
module magic_cell_array #(
    parameter int unsigned CELLS = 32,
    parameter int unsigned IN_W  = 8,
    parameter int unsigned AW    = $clog2(CELLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_en,
    input  logic [IN_W-1:0] load_vec,
    input  logic            set_en,
    input  logic            nor_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [AW-1:0]   ra_addr,
    input  logic [AW-1:0]   rb_addr,
    input  logic [AW-1:0]   rc_addr,
    output logic            ra_data,
    output logic            rb_data,
    output logic            rc_data
);

    localparam int unsigned NEXT = 1 << AW;

    logic [CELLS-1:0] cells_q;
    logic [NEXT-1:0]  cells_ext;
    logic             nor_src;

    // Pad the address space with constant ones so unmapped addresses read as 1.
    generate
        if (NEXT > CELLS) begin : g_pad
            assign cells_ext = {{(NEXT - CELLS){1'b1}}, cells_q};
        end else begin : g_nopad
            assign cells_ext = cells_q;
        end
    endgenerate

    assign ra_data = cells_ext[ra_addr];
    assign rb_data = cells_ext[rb_addr];
    assign rc_data = cells_ext[rc_addr];
    assign nor_src = ra_data | rb_data | rc_data;

    // A NOR can only pull a cell 1->0; sources are sampled before the write,
    // so dst aliasing a source sees the old value. Unmatched wr_addr is a no-op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cells_q <= '1;
        end else if (load_en) begin
            cells_q <= {{(CELLS - IN_W){1'b1}}, load_vec};
        end else begin
            for (int i = 0; i < CELLS; i++) begin
                if (wr_addr == AW'(i)) begin
                    if (set_en) begin
                        cells_q[i] <= 1'b1;
                    end else if (nor_en) begin
                        cells_q[i] <= cells_q[i] & ~nor_src;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/magic_nor_exec.sv
// Sequential MAGIC NOR evaluator: loads an input vector, then executes one
// INIT/NOR/READ/END micro-op per cycle on a bit-cell array.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : input vector handshake (accepted in IDLE)
//   in_vec              : input vector, bit i -> cell i
//   ins_valid/ins_ready : instruction handshake (accepted in RUN)
//   ins                 : {op[1:0], dst, a, b, c}
//   out_valid/out_ready : result handshake for READ
//   out_bit             : cell value captured by READ
//   err                 : sticky, set by INIT/NOR targeting an input cell
//   nor_cnt             : NORs executed since last vector load, saturating
module magic_nor_exec
    import magic_pkg::*;
#(
    parameter int unsigned CELLS = CELLS_DEF,
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned AW    = $clog2(CELLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_vec,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [2+4*AW-1:0] ins,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic              err,
    output logic [15:0]       nor_cnt
);

    localparam int unsigned IW = 2 + 4 * AW;

    state_e        state_q, state_d;
    op_e           op;
    logic [AW-1:0] dst, src_a, src_b, src_c;
    logic          in_fire, ins_fire, out_fire;
    logic          dst_prot, wr_ok, set_en, nor_en;
    logic          ra_data, rb_data, rc_data;
    logic          out_valid_q, out_bit_q, err_q;
    logic [15:0]   nor_cnt_q;

    assign op    = op_e'(ins[IW-1 -: 2]);
    assign dst   = ins[4*AW-1 -: AW];
    assign src_a = ins[3*AW-1 -: AW];
    assign src_b = ins[2*AW-1 -: AW];
    assign src_c = ins[AW-1:0];

    assign in_ready  = (state_q == S_IDLE);
    assign ins_ready = (state_q == S_RUN);
    assign in_fire   = in_valid & in_ready;
    assign ins_fire  = ins_valid & ins_ready;
    assign out_fire  = out_valid_q & out_ready;

    // Input cells are read-only once loaded.
    assign dst_prot = (32'(dst) < IN_W);
    assign wr_ok    = ins_fire & ~dst_prot;
    assign set_en   = wr_ok & (op == OP_INIT);
    assign nor_en   = wr_ok & (op == OP_NOR);

    magic_cell_array #(
        .CELLS (CELLS),
        .IN_W  (IN_W),
        .AW    (AW)
    ) u_cells (
        .clk      (clk),
        .rst      (rst),
        .load_en  (in_fire),
        .load_vec (in_vec),
        .set_en   (set_en),
        .nor_en   (nor_en),
        .wr_addr  (dst),
        .ra_addr  (src_a),
        .rb_addr  (src_b),
        .rc_addr  (src_c),
        .ra_data  (ra_data),
        .rb_data  (rb_data),
        .rc_data  (rc_data)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (in_fire) state_d = S_RUN;
            S_RUN: begin
                if (ins_fire) begin
                    unique case (op)
                        OP_READ: state_d = S_OUT;
                        OP_END:  state_d = S_IDLE;
                        default: state_d = S_RUN;
                    endcase
                end
            end
            S_OUT:   if (out_fire) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            err_q       <= 1'b0;
            nor_cnt_q   <= '0;
        end else begin
            state_q <= state_d;

            if (ins_fire && op == OP_READ) begin
                out_valid_q <= 1'b1;
                out_bit_q   <= ra_data;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end

            if (ins_fire && dst_prot && (op == OP_INIT || op == OP_NOR)) begin
                err_q <= 1'b1;
            end

            if (in_fire) begin
                nor_cnt_q <= '0;
            end else if (nor_en && nor_cnt_q != 16'hFFFF) begin
                nor_cnt_q <= nor_cnt_q + 16'd1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign err       = err_q;
    assign nor_cnt   = nor_cnt_q;

endmodule

// File: tb/tb_magic_nor_exec.sv
// Self-checking bench for magic_nor_exec: directed scenarios plus randomized
// programs compared against a behavioural cell-array model.
module tb_magic_nor_exec;
    import magic_pkg::*;

    localparam int CELLS = 32;
    localparam int IN_W  = 8;
    localparam int AW    = 5;
    localparam int IW    = 2 + 4 * AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_vec;
    logic          ins_valid;
    logic          ins_ready;
    logic [IW-1:0] ins;
    logic          out_valid;
    logic          out_ready;
    logic          out_bit;
    logic          err;
    logic [15:0]   nor_cnt;

    magic_nor_exec dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .ins       (ins),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .err       (err),
        .nor_cnt   (nor_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model
    bit m_cells[CELLS];
    bit m_err;
    int m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_rd(input int addr);
        return (addr < CELLS) ? m_cells[addr] : 1'b1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < CELLS; i++) m_cells[i] = 1'b1;
        m_err = 1'b0;
        m_cnt = 0;
    endtask

    task automatic m_apply(input logic [1:0] op, input int dst, input int a, input int b,
                           input int c);
        bit src;
        src = m_rd(a) | m_rd(b) | m_rd(c);
        if (op == OP_INIT || op == OP_NOR) begin
            if (dst < IN_W) begin
                m_err = 1'b1;
            end else if (dst < CELLS) begin
                if (op == OP_INIT) begin
                    m_cells[dst] = 1'b1;
                end else begin
                    m_cells[dst] = m_cells[dst] & ~src;
                end
            end
            if (op == OP_NOR && dst >= IN_W && m_cnt < 65535) m_cnt++;
        end
    endtask

    // All driving tasks start and end on a negative edge.
    task automatic load(input logic [7:0] v);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("load_in_ready", 32'(in_ready), 32'd1);
        in_vec   = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < CELLS; i++) m_cells[i] = (i < IN_W) ? v[i] : 1'b1;
        m_cnt = 0;
    endtask

    task automatic issue(input logic [1:0] op, input int dst, input int a, input int b,
                         input int c);
        int n = 0;
        while (!ins_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("issue_ins_ready", 32'(ins_ready), 32'd1);
        ins       = {op, AW'(dst), AW'(a), AW'(b), AW'(c)};
        ins_valid = 1'b1;
        m_apply(op, dst, a, b, c);
        @(negedge clk);
        ins_valid = 1'b0;
    endtask

    task automatic do_read(input int a, input int hold);
        bit exp;
        exp = m_rd(a);
        issue(OP_READ, 0, a, 0, 0);
        for (int k = 0; k <= hold; k++) begin
            check("read_valid", 32'(out_valid), 32'd1);
            check("read_bit", 32'(out_bit), 32'(exp));
            check("read_ins_ready_low", 32'(ins_ready), 32'd0);
            if (k < hold) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("read_valid_clr", 32'(out_valid), 32'd0);
        check("read_ins_ready_back", 32'(ins_ready), 32'd1);
    endtask

    task automatic finish_prog();
        check("nor_cnt", 32'(nor_cnt), 32'(m_cnt));
        check("err", 32'(err), 32'(m_err));
        issue(OP_END, 0, 0, 0, 0);
        check("end_in_ready", 32'(in_ready), 32'd1);
        check("end_ins_ready", 32'(ins_ready), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_vec    = '0;
        ins_valid = 1'b0;
        ins       = '0;
        out_ready = 1'b0;
        m_reset();
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_ins_ready", 32'(ins_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_bit", 32'(out_bit), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_nor_cnt", 32'(nor_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic NOR with a repeated operand
        load(8'h00);
        issue(OP_NOR, 8, 0, 1, 1);
        do_read(8, 0);
        check("basic_bit_direct", 32'(out_bit), 32'd1);
        finish_prog();
        load(8'h02);
        issue(OP_NOR, 8, 0, 1, 1);
        do_read(8, 0);
        check("basic_bit_direct2", 32'(out_bit), 32'd0);
        finish_prog();

        // Stickiness: a zeroed cell stays 0 until re-initialised
        load(8'h01);
        issue(OP_NOR, 9, 0, 0, 0);
        issue(OP_NOR, 9, 2, 2, 2);
        do_read(9, 1);
        issue(OP_INIT, 9, 0, 0, 0);
        issue(OP_NOR, 9, 2, 2, 2);
        do_read(9, 0);
        finish_prog();

        // Protection of input cells; err survives a reload
        load(8'hF7);
        issue(OP_INIT, 3, 0, 0, 0);
        check("prot_err", 32'(err), 32'd1);
        do_read(3, 0);
        check("prot_cnt", 32'(nor_cnt), 32'd0);
        finish_prog();
        load(8'h55);
        check("err_sticky", 32'(err), 32'd1);
        finish_prog();

        // Backpressure for three cycles
        load(8'h00);
        issue(OP_NOR, 12, 0, 1, 2);
        do_read(12, 3);
        finish_prog();

        // Back-to-back chain of 10 NORs
        load(8'($urandom));
        issue(OP_NOR, 8, 0, 1, 2);
        for (int k = 1; k < 10; k++) issue(OP_NOR, 8 + k, 7 + k, k % 8, 7 + k);
        do_read(17, 0);
        check("chain_cnt", 32'(nor_cnt), 32'd10);
        finish_prog();

        // Randomized programs
        for (int t = 0; t < 30; t++) begin
            load(8'($urandom));
            for (int n = 0; n < int'($urandom_range(5, 25)); n++) begin
                int r, dst;
                r   = $urandom_range(0, 99);
                dst = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(8, 31);
                if (r < 50) begin
                    issue(OP_NOR, dst, $urandom_range(0, 31), $urandom_range(0, 31),
                          $urandom_range(0, 31));
                end else if (r < 70) begin
                    issue(OP_INIT, dst, 0, 0, 0);
                end else begin
                    do_read($urandom_range(0, 31), $urandom_range(0, 3));
                end
            end
            finish_prog();
        end

        // Async reset while a result is pending
        load(8'h00);
        issue(OP_NOR, 20, 0, 0, 0);
        issue(OP_READ, 0, 20, 0, 0);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        m_reset();
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_ins_ready", 32'(ins_ready), 32'd0);
        check("arst_nor_cnt", 32'(nor_cnt), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        load(8'h00);
        do_read(20, 0);
        check("arst_cell20", 32'(out_bit), 32'd1);
        finish_prog();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
